// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_pkg : phase encoding and 1280x1024@60 timing constants          |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package vga_timing_pkg;

   typedef logic [1:0] phase_t;

   localparam phase_t c_ph_sync   = 2'd0;
   localparam phase_t c_ph_bp     = 2'd1;
   localparam phase_t c_ph_active = 2'd2;
   localparam phase_t c_ph_fp     = 2'd3;

   localparam int c_cnt_w      = 11;

   localparam int c_h_sync     = 112;
   localparam int c_h_bp       = 248;
   localparam int c_h_active   = 1280;
   localparam int c_h_fp       = 48;
   localparam int c_v_sync     = 3;
   localparam int c_v_bp       = 38;
   localparam int c_v_active   = 1024;
   localparam int c_v_fp       = 1;
   localparam int c_fetch_lat  = 2;

   function automatic int span_total(input int a, input int b, input int c, input int d);
      return a + b + c + d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_phase_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_phase_counter : one scan axis, SYNC -> BP -> ACTIVE -> FP phase FSM    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module vga_phase_counter
   import vga_timing_pkg::*;
#(
   parameter int SYNC_LEN   = c_h_sync,
   parameter int BP_LEN     = c_h_bp,
   parameter int ACTIVE_LEN = c_h_active,
   parameter int FP_LEN     = c_h_fp,
   parameter int CNT_W      = c_cnt_w
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             advance,
   output phase_t           phase,
   output logic [CNT_W-1:0] position,
   output logic             wrap
);

   phase_t           r_phase;
   logic [CNT_W-1:0] r_local;
   logic [CNT_W-1:0] r_pos;
   logic [CNT_W-1:0] w_last;
   logic             w_phase_end;

   // The phase is held as state; only the phase-local count decides the step.
   always_comb begin
      w_last = CNT_W'(FP_LEN - 1);
      case (r_phase)
         c_ph_sync:   w_last = CNT_W'(SYNC_LEN - 1);
         c_ph_bp:     w_last = CNT_W'(BP_LEN - 1);
         c_ph_active: w_last = CNT_W'(ACTIVE_LEN - 1);
         default:     w_last = CNT_W'(FP_LEN - 1);
      endcase
   end

   assign w_phase_end = (r_local == w_last);
   assign wrap        = advance && w_phase_end && (r_phase == c_ph_fp);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_phase <= c_ph_sync;
         r_local <= '0;
         r_pos   <= '0;
      end else if (clear) begin
         r_phase <= c_ph_sync;
         r_local <= '0;
         r_pos   <= '0;
      end else if (advance) begin
         if (w_phase_end) begin
            r_phase <= r_phase + 2'd1;
            r_local <= '0;
         end else begin
            r_local <= r_local + CNT_W'(1);
         end
         r_pos <= wrap ? '0 : r_pos + CNT_W'(1);
      end
   end

   assign phase    = r_phase;
   assign position = r_pos;

endmodule
`default_nettype wire

// File: rtl/vga_timing_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_sequencer : VGA scan timing, pixel fetch and registered pins    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module vga_timing_sequencer
   import vga_timing_pkg::*;
#(
   parameter int   H_SYNC    = c_h_sync,
   parameter int   H_BP      = c_h_bp,
   parameter int   H_ACTIVE  = c_h_active,
   parameter int   H_FP      = c_h_fp,
   parameter int   V_SYNC    = c_v_sync,
   parameter int   V_BP      = c_v_bp,
   parameter int   V_ACTIVE  = c_v_active,
   parameter int   V_FP      = c_v_fp,
   parameter logic SYNC_POL  = 1'b1,
   parameter int   FETCH_LAT = c_fetch_lat
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   output logic        pix_req,
   output logic [10:0] pix_x,
   output logic [10:0] pix_y,
   input  logic        pix_valid,
   input  logic [23:0] pix_rgb,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        vga_blank_n,
   output logic [7:0]  vga_R,
   output logic [7:0]  vga_G,
   output logic [7:0]  vga_B,
   output logic        frame_start,
   output logic        underflow
);

   localparam int c_h_total = span_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
   localparam int c_v_total = span_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

   localparam logic [c_cnt_w-1:0] c_req_lo = c_cnt_w'(H_SYNC + H_BP - FETCH_LAT);
   localparam logic [c_cnt_w-1:0] c_req_hi = c_cnt_w'(H_SYNC + H_BP - FETCH_LAT + H_ACTIVE);
   localparam logic [c_cnt_w-1:0] c_row_lo = c_cnt_w'(V_SYNC + V_BP);
   localparam logic [c_cnt_w-1:0] c_row_hi = c_cnt_w'(V_SYNC + V_BP + V_ACTIVE);

   generate
      if (c_h_total > 2047 || c_v_total > 2047 ||
          FETCH_LAT < 1 || FETCH_LAT > H_SYNC + H_BP) begin : g_bad_params
         $error("vga_timing_sequencer: illegal timing parameters");
      end
   endgenerate

   phase_t             w_h_phase;
   phase_t             w_v_phase;
   logic [c_cnt_w-1:0] w_h_pos;
   logic [c_cnt_w-1:0] w_v_pos;
   logic               w_h_wrap;
   logic               w_v_wrap;
   logic               w_clear;
   logic [c_cnt_w-1:0] w_h_next;
   logic [c_cnt_w-1:0] w_v_next;
   logic               w_req_next;
   logic               w_active;

   logic               r_pix_req;
   logic [10:0]        r_pix_x;
   logic [10:0]        r_pix_y;
   logic               r_hsync;
   logic               r_vsync;
   logic               r_blank_n;
   logic [23:0]        r_rgb;
   logic               r_frame_start;
   logic               r_underflow;

   assign w_clear = ~enable;

   vga_phase_counter #(
      .SYNC_LEN   (H_SYNC),
      .BP_LEN     (H_BP),
      .ACTIVE_LEN (H_ACTIVE),
      .FP_LEN     (H_FP),
      .CNT_W      (c_cnt_w)
   ) u_h_counter (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (w_clear),
      .advance  (enable),
      .phase    (w_h_phase),
      .position (w_h_pos),
      .wrap     (w_h_wrap)
   );

   vga_phase_counter #(
      .SYNC_LEN   (V_SYNC),
      .BP_LEN     (V_BP),
      .ACTIVE_LEN (V_ACTIVE),
      .FP_LEN     (V_FP),
      .CNT_W      (c_cnt_w)
   ) u_v_counter (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (w_clear),
      .advance  (w_h_wrap),
      .phase    (w_v_phase),
      .position (w_v_pos),
      .wrap     (w_v_wrap)
   );

   // pix_req is registered, so the window is evaluated on the position the
   // counters will hold next cycle; the request then coincides with h itself.
   always_comb begin
      w_h_next = w_h_wrap ? '0 : w_h_pos + c_cnt_w'(1);
      w_v_next = w_v_pos;
      if (w_h_wrap) begin
         w_v_next = w_v_wrap ? '0 : w_v_pos + c_cnt_w'(1);
      end
   end

   assign w_req_next = (w_h_next >= c_req_lo) && (w_h_next < c_req_hi) &&
                       (w_v_next >= c_row_lo) && (w_v_next < c_row_hi);

   assign w_active = (w_h_phase == c_ph_active) && (w_v_phase == c_ph_active);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pix_req     <= 1'b0;
         r_pix_x       <= '0;
         r_pix_y       <= '0;
         r_hsync       <= ~SYNC_POL;
         r_vsync       <= ~SYNC_POL;
         r_blank_n     <= 1'b0;
         r_rgb         <= '0;
         r_frame_start <= 1'b0;
         r_underflow   <= 1'b0;
      end else if (!enable) begin
         r_pix_req     <= 1'b0;
         r_pix_x       <= '0;
         r_pix_y       <= '0;
         r_hsync       <= ~SYNC_POL;
         r_vsync       <= ~SYNC_POL;
         r_blank_n     <= 1'b0;
         r_rgb         <= '0;
         r_frame_start <= 1'b0;
         r_underflow   <= 1'b0;
      end else begin
         r_pix_req     <= w_req_next;
         if (w_req_next) begin
            r_pix_x <= w_h_next - c_req_lo;
            r_pix_y <= w_v_next - c_row_lo;
         end
         r_hsync       <= (w_h_phase == c_ph_sync) ? SYNC_POL : ~SYNC_POL;
         r_vsync       <= (w_v_phase == c_ph_sync) ? SYNC_POL : ~SYNC_POL;
         r_blank_n     <= w_active;
         r_rgb         <= (w_active && pix_valid) ? pix_rgb : '0;
         r_frame_start <= (w_h_pos == '0) && (w_v_pos == '0);
         r_underflow   <= w_active && !pix_valid;
      end
   end

   assign pix_req     = r_pix_req;
   assign pix_x       = r_pix_x;
   assign pix_y       = r_pix_y;
   assign vga_hsync   = r_hsync;
   assign vga_vsync   = r_vsync;
   assign vga_blank_n = r_blank_n;
   assign vga_R       = r_rgb[23:16];
   assign vga_G       = r_rgb[15:8];
   assign vga_B       = r_rgb[7:0];
   assign frame_start = r_frame_start;
   assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_timing_sequencer : scoreboard bench on a shrunken timing set        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_vga_timing_sequencer;

   localparam int HS = 4, HB = 6, HA = 8, HF = 3, HT = 21;
   localparam int VS = 2, VB = 3, VA = 4, VF = 2, VT = 11;
   localparam int FT = 231;
   localparam int FL = 2;
   localparam int DROP_K = 5, DROP_L = 2;

   typedef struct { int c; int x; int y; } req_t;
   typedef struct { int c; logic [23:0] rgb; logic uf; } pix_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        pix_req;
   logic [10:0] pix_x;
   logic [10:0] pix_y;
   logic        pix_valid = 1'b0;
   logic [23:0] pix_rgb = '0;
   logic        vga_hsync, vga_vsync, vga_blank_n;
   logic [7:0]  vga_R, vga_G, vga_B;
   logic        frame_start;
   logic        underflow;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic src_const = 1'b0;
   logic drop_en = 1'b0;
   int   hold_x = 0, hold_y = 0;
   logic prev_hs = 1'b0, prev_vs = 1'b0;

   req_t q_req[$];
   pix_t q_pix[$];
   int   q_ev[5][$];   // 0 frame_start, 1 hs rise, 2 hs fall, 3 vs rise, 4 vs fall

   logic        pv_pipe  [FL];
   logic [23:0] rgb_pipe [FL];

   vga_timing_sequencer #(
      .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
      .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
      .SYNC_POL(1'b1), .FETCH_LAT(FL)
   ) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable),
      .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
      .pix_valid(pix_valid), .pix_rgb(pix_rgb),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
      .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B),
      .frame_start(frame_start), .underflow(underflow)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [23:0] pat(input int x, input int y);
      return {8'(x * 3 + 1), 8'(y * 7 + 2), 8'hC3};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
      end
   endtask

   // Expected response of a scan enabled at cycle e and aborted at cycle a.
   task automatic plan(input int e, input int a);
      int p, h, v, k, l;
      for (int c = e; c <= a; c++) begin
         p = (c - e) % FT;
         h = p % HT;
         v = p / HT;
         l = v - (VS + VB);
         k = h - (HS + HB) + FL;
         if (l >= 0 && l < VA && k >= 0 && k < HA) q_req.push_back('{c, k, l});
         if (c < a) begin
            if (h == 0 && v == 0)  begin q_ev[0].push_back(c + 1); q_ev[3].push_back(c + 1); end
            if (h == 0 && v == VS) q_ev[4].push_back(c + 1);
            if (h == 0)            q_ev[1].push_back(c + 1);
            if (h == HS)           q_ev[2].push_back(c + 1);
            k = h - (HS + HB);
            if (l >= 0 && l < VA && k >= 0 && k < HA) begin
               if (src_const)
                  q_pix.push_back('{c + 1, 24'hFF8000, 1'b0});
               else if (drop_en && k == DROP_K && l == DROP_L)
                  q_pix.push_back('{c + 1, 24'h000000, 1'b1});
               else
                  q_pix.push_back('{c + 1, pat(k, l), 1'b0});
            end
         end
      end
      p = (a - 1 - e) % FT;
      if ((p % HT) < HS) q_ev[2].push_back(a + 1);
      if ((p / HT) < VS) q_ev[4].push_back(a + 1);
   endtask

   task automatic wait_cyc(input int a);
      while (cyc < a) @(negedge clock);
      #1;
   endtask

   task automatic chk_idle(input string name);
      chk(name, {vga_hsync, vga_vsync, vga_blank_n, pix_req, frame_start, underflow,
                 pix_x, pix_y, vga_R, vga_G, vga_B}, 64'd0);
   endtask

   task automatic chk_drained(input string name);
      chk(name, q_req.size() + q_pix.size() + q_ev[0].size() + q_ev[1].size() +
                q_ev[2].size() + q_ev[3].size() + q_ev[4].size(), 0);
   endtask

   task automatic ev_check(input int kind, input string name);
      chk({name, "_expected"}, q_ev[kind].size() > 0, 1);
      if (q_ev[kind].size() > 0) chk(name, cyc, q_ev[kind].pop_front());
   endtask

   // Pixel source: answers each request exactly FL cycles later.
   always @(negedge clock) begin
      pix_valid = pv_pipe[FL-1];
      pix_rgb   = pv_pipe[FL-1] ? rgb_pipe[FL-1] : 24'h5A5A5A;
      for (int i = FL - 1; i > 0; i--) begin
         pv_pipe[i]  = pv_pipe[i-1];
         rgb_pipe[i] = rgb_pipe[i-1];
      end
      pv_pipe[0]  = pix_req && !(drop_en && pix_x == 11'(DROP_K) && pix_y == 11'(DROP_L));
      rgb_pipe[0] = pat(int'(pix_x), int'(pix_y));
      if (src_const) begin
         pix_valid = 1'b1;
         pix_rgb   = 24'hFF8000;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   req_t m_req;
   pix_t m_pix;
   always @(negedge clock) begin
      if (pix_req) begin
         chk("req_expected", q_req.size() > 0, 1);
         if (q_req.size() > 0) begin
            m_req = q_req.pop_front();
            chk("req_cycle", cyc, m_req.c);
            chk("req_x", pix_x, m_req.x);
            chk("req_y", pix_y, m_req.y);
            hold_x = m_req.x;
            hold_y = m_req.y;
         end
      end else begin
         chk("pix_xy_hold", {pix_x, pix_y}, {11'(hold_x), 11'(hold_y)});
      end
      if (vga_blank_n) begin
         chk("pix_expected", q_pix.size() > 0, 1);
         if (q_pix.size() > 0) begin
            m_pix = q_pix.pop_front();
            chk("pix_cycle", cyc, m_pix.c);
            chk("pix_rgb", {vga_R, vga_G, vga_B}, m_pix.rgb);
            chk("pix_underflow", underflow, m_pix.uf);
         end
      end else begin
         chk("blank_rgb_uf", {vga_R, vga_G, vga_B, underflow}, 0);
      end
      if (frame_start)              ev_check(0, "frame_start");
      if (vga_hsync && !prev_hs)    ev_check(1, "hsync_rise");
      if (!vga_hsync && prev_hs)    ev_check(2, "hsync_fall");
      if (vga_vsync && !prev_vs)    ev_check(3, "vsync_rise");
      if (!vga_vsync && prev_vs)    ev_check(4, "vsync_fall");
      prev_hs = vga_hsync;
      prev_vs = vga_vsync;
   end

   initial begin
      #200000;
      $display("FAIL watchdog at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int e, a;
      for (int i = 0; i < FL; i++) begin
         pv_pipe[i]  = 1'b0;
         rgb_pipe[i] = '0;
      end
      reset_n = 1'b1;
      enable  = 1'b0;
      #1 reset_n = 1'b0;
      #1 chk_idle("reset_values");
      wait_cyc(3);
      reset_n = 1'b1;
      wait_cyc(6);
      chk_idle("idle_disabled");

      // Constant source, one full frame then disable mid-frame.
      src_const = 1'b1;
      e = cyc;
      a = e + FT + 50;
      plan(e, a);
      enable = 1'b1;
      wait_cyc(a);
      enable = 1'b0;
      hold_x = 0; hold_y = 0;
      wait_cyc(a + 1);
      chk_idle("idle_after_disable");
      chk_drained("drained_const");

      // Re-enable with pattern source and one dropped pixel, then async reset at h=12, v=7.
      wait_cyc(a + 4);
      src_const = 1'b0;
      drop_en   = 1'b1;
      e = cyc;
      a = e + FT + 7 * HT + 12;
      plan(e, a);
      enable = 1'b1;
      wait_cyc(a);
      reset_n = 1'b0;
      hold_x = 0; hold_y = 0;
      #1 chk_idle("async_reset_immediate");
      wait_cyc(a + 1);
      chk_drained("drained_reset");
      wait_cyc(a + 4);

      // Release reset with enable held high: two full frames.
      e = cyc;
      a = e + 2 * FT + 10;
      plan(e, a);
      reset_n = 1'b1;
      wait_cyc(a);
      enable = 1'b0;
      hold_x = 0; hold_y = 0;
      wait_cyc(a + 1);
      chk_idle("idle_final");
      chk_drained("drained_final");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
